// File: rtl/cfg_ram_pkg.sv
// Shared definitions for the double-buffered parser config RAM group.
// Optional feature macro used by the RTL files: CFG_RAM_PARITY_EN.
package cfg_ram_pkg;

  // Width of one write segment on the shared cfg write bus.
  localparam int SEG_W = 64;

  // Commit sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2,
    ST_COPY  = 2'd3
  } cfg_state_t;

  // Global segment id owned by local segment j of group ram_index.
  function automatic int unsigned seg_id(input int unsigned ram_index,
                                         input int unsigned seg_num,
                                         input int unsigned j);
    return ram_index * seg_num + j;
  endfunction

endpackage

// File: rtl/cfg_ram_seg.sv
// One 64-bit segment column of the config RAM group, holding both banks.
// bank_sel names the active bank; the other bank is the shadow that takes
// writes and COPY updates. With CFG_RAM_PARITY_EN defined, one even-parity
// bit per row travels with the data and is checked on the active read.
module cfg_ram_seg
  import cfg_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SEG_W-1:0]      wr_data,
  input  logic                  copy_en,
  input  logic [ADDR_WIDTH-1:0] copy_addr,
  input  logic                  bank_sel,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
`ifdef CFG_RAM_PARITY_EN
  output logic                  rd_par_err,
`endif
  output logic [SEG_W-1:0]      rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][SEG_W-1:0] bank0;
  logic [DEPTH-1:0][SEG_W-1:0] bank1;

  // Shadow bank update: host writes and the post-swap copy never overlap,
  // since writes are refused while the commit sequencer is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      if (wr_en) begin
        if (bank_sel) bank0[wr_addr] <= wr_data;
        else          bank1[wr_addr] <= wr_data;
      end
      if (copy_en) begin
        if (bank_sel) bank0[copy_addr] <= bank1[copy_addr];
        else          bank1[copy_addr] <= bank0[copy_addr];
      end
    end
  end

  assign rd_data = bank_sel ? bank1[rd_addr] : bank0[rd_addr];

`ifdef CFG_RAM_PARITY_EN
  logic [DEPTH-1:0] par0;
  logic [DEPTH-1:0] par1;
  logic             rd_par;

  // Parity bits follow exactly the same write/copy path as the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par0 <= '0;
      par1 <= '0;
    end else begin
      if (wr_en) begin
        if (bank_sel) par0[wr_addr] <= ^wr_data;
        else          par1[wr_addr] <= ^wr_data;
      end
      if (copy_en) begin
        if (bank_sel) par0[copy_addr] <= par1[copy_addr];
        else          par1[copy_addr] <= par0[copy_addr];
      end
    end
  end

  assign rd_par     = bank_sel ? par1[rd_addr] : par0[rd_addr];
  assign rd_par_err = (^rd_data) ^ rd_par;
`endif

endmodule

// File: rtl/cfg_ram_dbuf_mux.sv
// Double-buffered parser config RAM group. Host writes fill the shadow bank
// in 64-bit segments; commit_req drains the write stage, swaps banks, then
// copies the new active bank into the new shadow so both stay coherent.
// The parser reads only the active bank, so tables never change mid-packet.
// Optional feature macro: CFG_RAM_PARITY_EN (per-segment even parity, par_err).
module cfg_ram_dbuf_mux
  import cfg_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 256,
  parameter int SEL_WIDTH  = 4,
  parameter int RAM_INDEX  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [SEL_WIDTH-1:0]  sram_sel,
  input  logic                  wr_en,
  input  logic [SEG_W-1:0]      din,
  output logic                  wr_ready,
  input  logic                  commit_req,
  output logic                  commit_done,
  output logic                  busy,
  output logic                  bank_sel,
  output logic [1:0]            err,
  input  logic                  err_clr,
  output logic                  par_err
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int SEG_NUM = DATA_WIDTH / SEG_W;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  cfg_state_t state;
  cfg_state_t state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic copy_en;
  logic swap_en;

  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic [SEG_W-1:0]      w_din;

  logic wr_acc;
  logic wr_drop;
  logic commit_drop;

  logic [DATA_WIDTH-1:0] rd_word;

  assign busy        = (state != ST_IDLE);
  assign wr_ready    = ~busy;
  assign wr_acc      = wr_en & ~busy;
  assign wr_drop     = wr_en & busy;
  assign commit_drop = commit_req & busy;

  // Write stage: strobe only counts when accepted; payload needs no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_en <= 1'b0;
    else        w_en <= wr_acc;
  end

  // Write stage payload capture.
  always_ff @(posedge clk) begin
    w_addr <= addr_wr;
    w_sel  <= sram_sel;
    w_din  <= din;
  end

  // Commit sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Commit sequencer next state and per-state strobes.
  always_comb begin
    state_nxt   = state;
    swap_en     = 1'b0;
    copy_en     = 1'b0;
    commit_done = 1'b0;
    case (state)
      ST_IDLE:  if (commit_req) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_SWAP;
      ST_SWAP: begin
        swap_en   = 1'b1;
        state_nxt = ST_COPY;
      end
      ST_COPY: begin
        copy_en = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt   = ST_IDLE;
          commit_done = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Copy row counter: cleared on the swap, advances once per COPY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (swap_en) cnt <= '0;
    else if (copy_en) cnt <= cnt + 1'b1;
  end

  // Active bank index flips exactly once per accepted commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bank_sel <= 1'b0;
    else if (swap_en) bank_sel <= ~bank_sel;
  end

  // Sticky error flags; a new event in the clearing cycle keeps its bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else begin
      err[0] <= (err[0] & ~err_clr) | wr_drop;
      err[1] <= (err[1] & ~err_clr) | commit_drop;
    end
  end

`ifdef CFG_RAM_PARITY_EN
  logic [SEG_NUM-1:0] rd_perr;
`endif

  for (genvar j = 0; j < SEG_NUM; j++) begin : g_seg
    localparam logic [SEL_WIDTH-1:0] SID =
      SEL_WIDTH'(seg_id(RAM_INDEX, SEG_NUM, j));
    logic seg_we;
    assign seg_we = w_en & (w_sel == SID);

    cfg_ram_seg #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_seg (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (seg_we),
      .wr_addr   (w_addr),
      .wr_data   (w_din),
      .copy_en   (copy_en),
      .copy_addr (cnt),
      .bank_sel  (bank_sel),
      .rd_addr   (addr_rd),
`ifdef CFG_RAM_PARITY_EN
      .rd_par_err(rd_perr[j]),
`endif
      .rd_data   (rd_word[SEG_W*j +: SEG_W])
    );
  end

  // Registered active-bank read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= rd_word;
  end

`ifdef CFG_RAM_PARITY_EN
  // Parity flag registered alongside the read data it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= |rd_perr;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_ram_dbuf_mux.sv
// Testbench for cfg_ram_dbuf_mux (DEPTH=4, four 64-bit segments, RAM_INDEX=0).
module tb_cfg_ram_dbuf_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   addr_rd;
  logic [255:0] dout;
  logic [1:0]   addr_wr;
  logic [3:0]   sram_sel;
  logic         wr_en;
  logic [63:0]  din;
  logic         wr_ready;
  logic         commit_req;
  logic         commit_done;
  logic         busy;
  logic         bank_sel;
  logic [1:0]   err;
  logic         err_clr;
  logic         par_err;

  cfg_ram_dbuf_mux #(
    .ADDR_WIDTH(2), .DATA_WIDTH(256), .SEL_WIDTH(4), .RAM_INDEX(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr_rd(addr_rd), .dout(dout),
    .addr_wr(addr_wr), .sram_sel(sram_sel), .wr_en(wr_en), .din(din),
    .wr_ready(wr_ready), .commit_req(commit_req), .commit_done(commit_done),
    .busy(busy), .bank_sel(bank_sel), .err(err), .err_clr(err_clr),
    .par_err(par_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: logical active/shadow contents, indexed [row][segment].
  logic [63:0] m_act [4][4];
  logic [63:0] m_shd [4][4];
  logic        m_bs;

  typedef struct {
    logic [3:0]  sel;
    logic [1:0]  row;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] m_row(input int r);
    return {m_act[r][3], m_act[r][2], m_act[r][1], m_act[r][0]};
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 4; r++)
      for (int s = 0; s < 4; s++) begin
        m_act[r][s] = '0;
        m_shd[r][s] = '0;
      end
    m_bs = 1'b0;
  endtask

  task automatic m_write(input logic [3:0] sel, input logic [1:0] row, input logic [63:0] d);
    if (sel < 4) m_shd[row][sel[1:0]] = d;
  endtask

  task automatic m_commit();
    m_act = m_shd;
    m_bs  = ~m_bs;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [1:0] row, input logic [63:0] d);
    sram_sel = sel; addr_wr = row; din = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    m_write(sel, row, d);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] row);
    addr_rd = row;
    tick();
    chk(nm, dout, m_row(row));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk(nm, busy, 0);
  endtask

  // Issue a commit (optionally alongside a write already on the bus) and
  // measure the busy window and the commit_done pulse position.
  task automatic do_commit(input string nm);
    int bcnt = 0;
    int dcnt = 0;
    int dat  = -1;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      bcnt++;
      if (commit_done) begin
        dcnt++;
        dat = bcnt;
      end
      tick();
    end
    chk({nm, "_busy_len"}, bcnt, 6);
    chk({nm, "_done_cnt"}, dcnt, 1);
    chk({nm, "_done_pos"}, dat, 6);
    chk({nm, "_done_idle"}, commit_done, 0);
    m_commit();
    chk({nm, "_bank_sel"}, bank_sel, m_bs);
  endtask

  initial begin
    logic [255:0] old_row, new_row, exp_row;
    logic prev_bs, bs0;
    bit saw_new;
    int op;
    logic [3:0] rsel;
    logic [1:0] rrow;
    logic [63:0] rdin;

    rst_n = 1'b0; addr_rd = '0; addr_wr = '0; sram_sel = '0; wr_en = 1'b0;
    din = '0; commit_req = 1'b0; err_clr = 1'b0;
    m_clear();

    tbl[0] = '{sel: 4'd0,  row: 2'd0, din: 64'h0123_4567_89AB_CDEF, exp: 64'h0123_4567_89AB_CDEF};
    tbl[1] = '{sel: 4'd1,  row: 2'd1, din: 64'hFFFF_0000_FFFF_0000, exp: 64'hFFFF_0000_FFFF_0000};
    tbl[2] = '{sel: 4'd2,  row: 2'd3, din: 64'h8000_0000_0000_0001, exp: 64'h8000_0000_0000_0001};
    tbl[3] = '{sel: 4'd3,  row: 2'd2, din: 64'hFFFF_FFFF_FFFF_FFFF, exp: 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{sel: 4'd7,  row: 2'd0, din: 64'hDEAD_BEEF_DEAD_BEEF, exp: 64'h0};
    tbl[5] = '{sel: 4'd15, row: 2'd1, din: 64'hCAFE_F00D_CAFE_F00D, exp: 64'h0};

    // 1: reset state
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_par_err", par_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_wr_ready", wr_ready, 1);
    for (int r = 0; r < 4; r++) rd_chk($sformatf("rst_row%0d", r), 2'(r));

    // 2: write to shadow is invisible until commit
    wr(4'd1, 2'd2, 64'hA5A5_0000_0000_0001);
    tick();
    addr_rd = 2'd2;
    tick();
    chk("pre_commit_row2", dout, 0);
    do_commit("commit1");
    addr_rd = 2'd2;
    tick();
    chk("post_commit_seg1", dout[127:64], 64'hA5A5_0000_0000_0001);
    chk("post_commit_row2", dout, m_row(2));

    // 3: commit with no writes keeps data (copy made the shadow coherent)
    do_commit("commit2");
    addr_rd = 2'd2;
    tick();
    chk("recommit_seg1", dout[127:64], 64'hA5A5_0000_0000_0001);
    chk("recommit_err", err, 0);

    // 5: read held across the swap edge
    wr(4'd0, 2'd2, 64'h1111_2222_3333_4444);
    addr_rd = 2'd2;
    tick();
    old_row = m_row(2);
    chk("swap_old_row", dout, old_row);
    bs0 = bank_sel;
    prev_bs = bank_sel;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    new_row = {m_shd[2][3], m_shd[2][2], m_shd[2][1], m_shd[2][0]};
    saw_new = 0;
    for (int i = 0; i < 8; i++) begin
      exp_row = (prev_bs == bs0) ? old_row : new_row;
      chk($sformatf("swap_rd_c%0d", i), dout, exp_row);
      if (dout === new_row) saw_new = 1;
      prev_bs = bank_sel;
      tick();
    end
    chk("swap_saw_new", saw_new, 1);
    chk("swap_idle", busy, 0);
    m_commit();

    // 4: dropped write and dropped commit, sticky error and clear priority
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    tick();
    chk("copy_wr_ready", wr_ready, 0);
    sram_sel = 4'd3; addr_wr = 2'd0; din = 64'hDEAD_0000_0000_BEEF; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("err_wr_drop", err, 2'b01);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("err_commit_drop", err, 2'b11);
    wait_idle("err_wait1");
    m_commit();
    chk("drop_single_swap", bank_sel, m_bs);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clear", err, 2'b00);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    wr_en = 1'b1; err_clr = 1'b1;
    tick();
    wr_en = 1'b0; err_clr = 1'b0;
    chk("err_set_wins", err, 2'b01);
    wait_idle("err_wait2");
    m_commit();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    rd_chk("dropped_wr_absent", 2'd0);

    // simultaneous write and commit in IDLE: write accepted into this commit
    sram_sel = 4'd2; addr_wr = 2'd1; din = 64'h0BAD_F00D_1234_5678; wr_en = 1'b1;
    m_write(4'd2, 2'd1, 64'h0BAD_F00D_1234_5678);
    do_commit("commit_wr");
    rd_chk("simul_wr_row1", 2'd1);
    chk("simul_wr_err", err, 0);

    // 6: reset in the middle of COPY
    wr(4'd3, 2'd3, 64'h7777_7777_7777_7777);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    tick();
    tick();
    chk("midcopy_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_dout", dout, 0);
    chk("midrst_bank_sel", bank_sel, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", commit_done, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    for (int r = 0; r < 4; r++) rd_chk($sformatf("midrst_row%0d", r), 2'(r));
    do_commit("midrst_commit");
    rd_chk("midrst_shadow_clear", 2'd3);

    // table-driven segment routing
    for (int i = 0; i < 6; i++) wr(tbl[i].sel, tbl[i].row, tbl[i].din);
    do_commit("tbl_commit");
    for (int i = 0; i < 6; i++) begin
      addr_rd = tbl[i].row;
      tick();
      chk($sformatf("tbl%0d", i), dout[64*tbl[i].sel[1:0] +: 64], tbl[i].exp);
    end

    // randomized traffic against the model
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        rsel = 4'($urandom_range(0, 15));
        rrow = 2'($urandom_range(0, 3));
        rdin = {32'($urandom), 32'($urandom)};
        wr(rsel, rrow, rdin);
      end else if (op <= 8) begin
        rd_chk($sformatf("rnd_rd%0d", i), 2'($urandom_range(0, 3)));
      end else begin
        do_commit($sformatf("rnd_commit%0d", i));
      end
    end
    do_commit("rnd_final");
    for (int r = 0; r < 4; r++) rd_chk($sformatf("rnd_row%0d", r), 2'(r));
    chk("rnd_err", err, 0);
    chk("rnd_par_err", par_err, 0);

`ifdef CFG_RAM_PARITY_EN
    begin
      logic [3:0] p0, p1;
      p0 = dut.g_seg[0].u_seg.par0;
      p1 = dut.g_seg[0].u_seg.par1;
      force dut.g_seg[0].u_seg.par0 = ~p0;
      force dut.g_seg[0].u_seg.par1 = ~p1;
      addr_rd = 2'd0;
      tick();
      chk("par_err_flip", par_err, 1);
      release dut.g_seg[0].u_seg.par0;
      release dut.g_seg[0].u_seg.par1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
